// File: rtl/tlp_recv.sv
// Receive-side TLP decoder: turns 3DW MWr/MRd requests on the 64-bit RX stream into
// one Action each (write, read or error) for the action pipe.
package tlp_xcvr_pkg;
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_WRITE = 2'd1,
    ACT_READ  = 2'd2,
    ACT_ERROR = 2'd3
  } ActType;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_FMT    = 3'd1,
    ERR_LEN    = 3'd2,
    ERR_SOP    = 3'd3,
    ERR_POISON = 3'd4
  } ErrorCode;

  // Flat view: READ uses reqID/tag/chan, WRITE uses chan/data, ERROR uses code.
  typedef struct packed {
    ActType      typ;
    logic [15:0] reqID;
    logic [7:0]  tag;
    logic [15:0] chan;
    logic [31:0] data;
    ErrorCode    code;
  } Action;
endpackage

module tlp_recv #(
  parameter int CHAN_NBITS    = 7,
  parameter bit DROP_POISONED = 1'b1
) (
  input  logic                pcieClk_in,
  input  logic                pcieRst_in,
  input  logic [63:0]         rxData_in,
  input  logic                rxValid_in,
  output logic                rxReady_out,
  input  logic                rxSOP_in,
  input  logic                rxEOP_in,
  output tlp_xcvr_pkg::Action actData_out,
  output logic                actValid_out,
  input  logic                actReady_in,
  output logic [15:0]         rxErrCount_out
);
  import tlp_xcvr_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR1 = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_is_wr;
  logic [15:0] r_reqid;
  logic [7:0]  r_tag;
  logic [15:0] r_chan;

  logic        w_acc;
  logic        w_emit;
  Action       w_act;
  state_t      w_next;
  logic        w_load_hdr;
  logic        w_load_chan;
  logic [15:0] w_chan;
  ErrorCode    w_hdr_err;

  function automatic Action mk_err(input ErrorCode c);
    Action a;
    a      = '0;
    a.typ  = ACT_ERROR;
    a.code = c;
    return a;
  endfunction

  // A free action slot is guaranteed for every accepted QW.
  assign rxReady_out = !actValid_out || actReady_in;
  assign w_acc       = rxValid_in && rxReady_out;

  always_comb begin
    w_chan = 16'(rxData_in[CHAN_NBITS+1:2]);
    if (rxData_in[28:24] != 5'd0 || (rxData_in[30:29] != 2'b10 && rxData_in[30:29] != 2'b00)) begin
      w_hdr_err = ERR_FMT;
    end else if (rxData_in[9:0] != 10'd1) begin
      w_hdr_err = ERR_LEN;
    end else if (rxData_in[14] && DROP_POISONED) begin
      w_hdr_err = ERR_POISON;
    end else begin
      w_hdr_err = ERR_NONE;
    end

    w_emit      = 1'b0;
    w_act       = '0;
    w_next      = r_state;
    w_load_hdr  = 1'b0;
    w_load_chan = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE, S_DROP: begin
          if (rxSOP_in) begin
            if (w_hdr_err != ERR_NONE) begin
              w_emit = 1'b1;
              w_act  = mk_err(w_hdr_err);
              w_next = rxEOP_in ? S_IDLE : S_DROP;
            end else begin
              w_load_hdr = 1'b1;
              w_next     = S_HDR1;
            end
          end else if (r_state == S_IDLE) begin
            w_emit = 1'b1;
            w_act  = mk_err(ERR_SOP);
            w_next = rxEOP_in ? S_IDLE : S_DROP;
          end else begin
            w_next = rxEOP_in ? S_IDLE : S_DROP;
          end
        end
        S_HDR1, S_DATA: begin
          // The SOP QW belongs to a new TLP that is dropped, not decoded.
          if (rxSOP_in) begin
            w_emit = 1'b1;
            w_act  = mk_err(ERR_SOP);
            w_next = rxEOP_in ? S_IDLE : S_DROP;
          end else if (r_state == S_HDR1 && r_is_wr && !rxData_in[2] && !rxEOP_in) begin
            w_load_chan = 1'b1;
            w_next      = S_DATA;
          end else if (!rxEOP_in || (r_state == S_HDR1 && r_is_wr && !rxData_in[2])) begin
            w_emit = 1'b1;
            w_act  = mk_err(ERR_LEN);
            w_next = rxEOP_in ? S_IDLE : S_DROP;
          end else if (r_state == S_HDR1 && !r_is_wr) begin
            w_emit      = 1'b1;
            w_act.typ   = ACT_READ;
            w_act.reqID = r_reqid;
            w_act.tag   = r_tag;
            w_act.chan  = w_chan;
            w_next      = S_IDLE;
          end else begin
            w_emit     = 1'b1;
            w_act.typ  = ACT_WRITE;
            w_act.chan = (r_state == S_HDR1) ? w_chan : r_chan;
            w_act.data = (r_state == S_HDR1) ? rxData_in[63:32] : rxData_in[31:0];
            w_next     = S_IDLE;
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end else begin
      w_next = r_state;
    end
  end

  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      r_state        <= S_IDLE;
      r_is_wr        <= 1'b0;
      r_reqid        <= 16'd0;
      r_tag          <= 8'd0;
      r_chan         <= 16'd0;
      actValid_out   <= 1'b0;
      actData_out    <= '0;
      rxErrCount_out <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_load_hdr) begin
        r_is_wr <= rxData_in[30];
        r_reqid <= rxData_in[63:48];
        r_tag   <= rxData_in[47:40];
      end
      if (w_load_chan) begin
        r_chan <= w_chan;
      end
      if (w_emit) begin
        actValid_out <= 1'b1;
        actData_out  <= w_act;
        if (w_act.typ == ACT_ERROR && rxErrCount_out != 16'hFFFF) begin
          rxErrCount_out <= rxErrCount_out + 16'd1;
        end
      end else if (actReady_in) begin
        actValid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tlp_recv.sv
// Directed self-checking bench for tlp_recv: hand-computed actions for writes, reads,
// back-pressure, malformed TLPs and the error counter.
module tb_tlp_recv;
  import tlp_xcvr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rxData_in;
  logic        rxValid_in;
  logic        rxReady_out;
  logic        rxSOP_in;
  logic        rxEOP_in;
  Action       actData_out;
  logic        actValid_out;
  logic        actReady_in;
  logic [15:0] rxErrCount_out;

  int checks   = 0;
  int failures = 0;

  tlp_recv #(.CHAN_NBITS(7), .DROP_POISONED(1'b1)) dut (
    .pcieClk_in    (clk),
    .pcieRst_in    (rst),
    .rxData_in     (rxData_in),
    .rxValid_in    (rxValid_in),
    .rxReady_out   (rxReady_out),
    .rxSOP_in      (rxSOP_in),
    .rxEOP_in      (rxEOP_in),
    .actData_out   (actData_out),
    .actValid_out  (actValid_out),
    .actReady_in   (actReady_in),
    .rxErrCount_out(rxErrCount_out)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // QW0: DW0 {0,fmt,type=0,0,TD=0,EP,0,len} and DW1 {reqID,tag,BE=FF}.
  function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic ep, input logic [9:0] len,
                                      input logic [15:0] rid, input logic [7:0] tg);
    return {rid, tg, 8'hFF, 1'b0, fmt, 5'd0, 8'h00, 1'b0, ep, 4'd0, len};
  endfunction

  // Offer one QW and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [63:0] d, input logic sop, input logic eop);
    int n;
    @(negedge clk);
    rxData_in  = d;
    rxSOP_in   = sop;
    rxEOP_in   = eop;
    rxValid_in = 1'b1;
    n = 0;
    while (!rxReady_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready", {63'd0, rxReady_out}, 64'd1);
    @(posedge clk);
    #1;
    rxValid_in = 1'b0;
    rxSOP_in   = 1'b0;
    rxEOP_in   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    rxData_in   = 64'd0;
    rxValid_in  = 1'b0;
    rxSOP_in    = 1'b0;
    rxEOP_in    = 1'b0;
    actReady_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, actValid_out}, 64'd0);
    check("rst_data", 64'(actData_out), 64'd0);
    check("rst_cnt", 64'(rxErrCount_out), 64'd0);
    check("rst_ready", {63'd0, rxReady_out}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // 1: MWr addr 0x14, payload in QW1 hi
    send(hdr(2'b10, 1'b0, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    check("t1_no_act_hdr", {63'd0, actValid_out}, 64'd0);
    send({32'hCAFEBABE, 32'h0000_0014}, 1'b0, 1'b1);
    check("t1_valid", {63'd0, actValid_out}, 64'd1);
    check("t1_typ", 64'(actData_out.typ), 64'(ACT_WRITE));
    check("t1_chan", 64'(actData_out.chan), 64'd5);
    check("t1_data", 64'(actData_out.data), 64'hCAFEBABE);

    // 2: MWr addr 0x10, payload in QW2 lo
    send(hdr(2'b10, 1'b0, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    send({32'h0000_0000, 32'h0000_0010}, 1'b0, 1'b0);
    check("t2_no_act_qw1", {63'd0, actValid_out}, 64'd0);
    send({32'h0000_0000, 32'h1234_5678}, 1'b0, 1'b1);
    check("t2_typ", 64'(actData_out.typ), 64'(ACT_WRITE));
    check("t2_chan", 64'(actData_out.chan), 64'd4);
    check("t2_data", 64'(actData_out.data), 64'h12345678);

    // 3: MRd reqID 0x0100 tag 0x2A addr 0x08
    send(hdr(2'b00, 1'b0, 10'd1, 16'h0100, 8'h2A), 1'b1, 1'b0);
    send({32'h0000_0000, 32'h0000_0008}, 1'b0, 1'b1);
    check("t3_typ", 64'(actData_out.typ), 64'(ACT_READ));
    check("t3_reqid", 64'(actData_out.reqID), 64'h0100);
    check("t3_tag", 64'(actData_out.tag), 64'h2A);
    check("t3_chan", 64'(actData_out.chan), 64'd2);
    @(posedge clk);
    #1;
    check("t3_consumed", {63'd0, actValid_out}, 64'd0);

    // 4: back-pressure with an action pending
    actReady_in = 1'b0;
    send(hdr(2'b10, 1'b0, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    send({32'h1111_1111, 32'h0000_000C}, 1'b0, 1'b1);
    @(negedge clk);
    rxData_in  = hdr(2'b00, 1'b0, 10'd1, 16'h0BEE, 8'h11);
    rxSOP_in   = 1'b1;
    rxEOP_in   = 1'b0;
    rxValid_in = 1'b1;
    check("t4_ready_low", {63'd0, rxReady_out}, 64'd0);
    repeat (3) @(negedge clk);
    check("t4_hold_valid", {63'd0, actValid_out}, 64'd1);
    check("t4_hold_data", 64'(actData_out.data), 64'h11111111);
    check("t4_hold_chan", 64'(actData_out.chan), 64'd3);
    check("t4_still_low", {63'd0, rxReady_out}, 64'd0);
    actReady_in = 1'b1;
    @(posedge clk);
    #1;
    rxValid_in = 1'b0;
    rxSOP_in   = 1'b0;
    check("t4_first_gone", {63'd0, actValid_out}, 64'd0);
    send({32'h0000_0000, 32'h0000_0018}, 1'b0, 1'b1);
    check("t4_second_typ", 64'(actData_out.typ), 64'(ACT_READ));
    check("t4_second_reqid", 64'(actData_out.reqID), 64'h0BEE);
    check("t4_second_tag", 64'(actData_out.tag), 64'h11);
    check("t4_second_chan", 64'(actData_out.chan), 64'd6);

    // 5: length=2 rejected, then a good write
    send(hdr(2'b10, 1'b0, 10'd2, 16'h0000, 8'h00), 1'b1, 1'b0);
    check("t5_typ", 64'(actData_out.typ), 64'(ACT_ERROR));
    check("t5_code", 64'(actData_out.code), 64'd2);
    check("t5_cnt", 64'(rxErrCount_out), 64'd1);
    send({32'h0000_0000, 32'h0000_0010}, 1'b0, 1'b0);
    check("t5_drop1", {63'd0, actValid_out}, 64'd0);
    send({32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b0, 1'b1);
    check("t5_drop2", {63'd0, actValid_out}, 64'd0);
    send(hdr(2'b10, 1'b0, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    send({32'hDEAD_BEEF, 32'h0000_001C}, 1'b0, 1'b1);
    check("t5_ok_typ", 64'(actData_out.typ), 64'(ACT_WRITE));
    check("t5_ok_chan", 64'(actData_out.chan), 64'd7);
    check("t5_ok_data", 64'(actData_out.data), 64'hDEADBEEF);
    check("t5_ok_cnt", 64'(rxErrCount_out), 64'd1);

    // poisoned write, then channel wrap (addr 0x204 -> DW 0x81 -> chan 1)
    send(hdr(2'b10, 1'b1, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    check("ep_code", 64'(actData_out.code), 64'd4);
    check("ep_cnt", 64'(rxErrCount_out), 64'd2);
    send({32'h5555_5555, 32'h0000_0004}, 1'b0, 1'b1);
    check("ep_dropped", {63'd0, actValid_out}, 64'd0);
    send(hdr(2'b10, 1'b0, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    send({32'hA5A5_A5A5, 32'h0000_0204}, 1'b0, 1'b1);
    check("wrap_chan", 64'(actData_out.chan), 64'd1);
    check("wrap_data", 64'(actData_out.data), 64'hA5A5A5A5);

    // reset mid-stream clears counter and outputs
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst2_valid", {63'd0, actValid_out}, 64'd0);
    check("rst2_cnt", 64'(rxErrCount_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 6: SOP inside S_HDR1, new TLP dropped; SOP in S_DROP decodes normally; 4DW -> ERR_FMT
    send(hdr(2'b00, 1'b0, 10'd1, 16'h0100, 8'h2A), 1'b1, 1'b0);
    send(hdr(2'b10, 1'b0, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    check("t6_sop_typ", 64'(actData_out.typ), 64'(ACT_ERROR));
    check("t6_sop_code", 64'(actData_out.code), 64'd3);
    check("t6_sop_cnt", 64'(rxErrCount_out), 64'd1);
    send(hdr(2'b10, 1'b0, 10'd1, 16'h0000, 8'h00), 1'b1, 1'b0);
    check("t6_drop_sop_silent", {63'd0, actValid_out}, 64'd0);
    send({32'h0BAD_F00D, 32'h0000_0004}, 1'b0, 1'b1);
    check("t6_drop_sop_typ", 64'(actData_out.typ), 64'(ACT_WRITE));
    check("t6_drop_sop_data", 64'(actData_out.data), 64'h0BADF00D);
    send(hdr(2'b01, 1'b0, 10'd1, 16'h0100, 8'h2A), 1'b1, 1'b0);
    check("t6_fmt_code", 64'(actData_out.code), 64'd1);
    check("t6_fmt_cnt", 64'(rxErrCount_out), 64'd2);
    send({32'h0000_0000, 32'h0000_0008}, 1'b0, 1'b1);
    check("t6_fmt_tail", {63'd0, actValid_out}, 64'd0);
    check("t6_final_cnt", 64'(rxErrCount_out), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
